// File: rtl/demux_lane_sched_pkg.sv
// Shared definitions for the receive-side lane scheduler: widths, idle symbol,
// FSM state encoding and the byte-pairing helper.
package demux_lane_sched_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam logic [BYTE_W-1:0] IDLE_SYM_DEF = 8'hBC;

    typedef enum logic {
        S_HI = 1'b0,
        S_LO = 1'b1
    } state_t;

    // First received byte lands in the upper half of the word.
    function automatic logic [WORD_W-1:0] make_word(input logic [BYTE_W-1:0] hi,
                                                    input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/demux_lane_sched_lane_fifo.sv
// Per-lane shift FIFO: entry 0 is always the head, so head_data comes straight
// from a register and every entry clears on reset.
module lane_fifo
    import demux_lane_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = WORD_W
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] shift_in [DEPTH];
    logic [CNT_W-1:0] cnt_reg;
    logic             do_pop;
    logic             do_push;
    logic [CNT_W-1:0] wr_idx;

    assign empty   = (cnt_reg == '0);
    assign full    = (cnt_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign wr_idx  = do_pop ? (cnt_reg - 1'b1) : cnt_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == DEPTH - 1) begin : g_last
                assign shift_in[gi] = '0;
            end else begin : g_mid
                assign shift_in[gi] = mem_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            cnt_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(do_push) - CNT_W'(do_pop);
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (wr_idx == CNT_W'(i))) begin
                    mem_reg[i] <= push_data;
                end else if (do_pop) begin
                    mem_reg[i] <= shift_in[i];
                end
            end
        end
    end

    assign head_data = mem_reg[0];

endmodule

// File: rtl/demux_lane_sched.sv
// Pairs incoming bytes into 16-bit words and deals them alternately to two
// lane FIFOs, tracking word count, overflow and partial-word errors.
module demux_lane_sched
    import demux_lane_sched_pkg::*;
#(
    parameter int                FIFO_DEPTH = 2,
    parameter logic [BYTE_W-1:0] IDLE_SYM   = IDLE_SYM_DEF
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              lane0_ready,
    input  logic              lane1_ready,
    input  logic              clear_err,
    output logic [WORD_W-1:0] lane0_data,
    output logic              lane0_valid,
    output logic [WORD_W-1:0] lane1_data,
    output logic              lane1_valid,
    output logic              err_overflow,
    output logic              err_partial,
    output logic [15:0]       word_cnt
);

    state_t            state_reg;
    logic [BYTE_W-1:0] hi_reg;
    logic              ptr_reg;
    logic [15:0]       word_cnt_reg;
    logic              err_overflow_reg;
    logic              err_partial_reg;

    logic              word_push;
    logic [WORD_W-1:0] word_data;
    logic              overflow_hit;

    logic              lane_ready [2];
    logic              lane_pop   [2];
    logic              lane_push  [2];
    logic              lane_full  [2];
    logic              lane_empty [2];
    logic [WORD_W-1:0] lane_head  [2];

    assign lane_ready[0] = lane0_ready;
    assign lane_ready[1] = lane1_ready;

    assign word_push = (state_reg == S_LO) && in_valid;
    assign word_data = make_word(hi_reg, in_data);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_pop[gi]  = !lane_empty[gi] && lane_ready[gi];
            assign lane_push[gi] = word_push && (ptr_reg == 1'(gi));

            lane_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (WORD_W)
            ) u_fifo (
                .clk_4f    (clk_4f),
                .reset     (reset),
                .push      (lane_push[gi]),
                .push_data (word_data),
                .pop       (lane_pop[gi]),
                .head_data (lane_head[gi]),
                .full      (lane_full[gi]),
                .empty     (lane_empty[gi])
            );
        end
    endgenerate

    // Dropped words still advance the pointer so lane parity never slips.
    assign overflow_hit = word_push && lane_full[ptr_reg] && !lane_pop[ptr_reg];

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_reg        <= S_HI;
            hi_reg           <= '0;
            ptr_reg          <= 1'b0;
            word_cnt_reg     <= '0;
            err_overflow_reg <= 1'b0;
            err_partial_reg  <= 1'b0;
        end else begin
            err_partial_reg <= 1'b0;
            if (overflow_hit) begin
                err_overflow_reg <= 1'b1;
            end else if (clear_err) begin
                err_overflow_reg <= 1'b0;
            end
            case (state_reg)
                S_HI: begin
                    if (in_valid && (in_data != IDLE_SYM)) begin
                        hi_reg    <= in_data;
                        state_reg <= S_LO;
                    end
                end
                S_LO: begin
                    state_reg <= S_HI;
                    if (in_valid) begin
                        ptr_reg      <= !ptr_reg;
                        word_cnt_reg <= word_cnt_reg + 16'd1;
                    end else begin
                        err_partial_reg <= 1'b1;
                    end
                end
                default: state_reg <= S_HI;
            endcase
        end
    end

    assign lane0_data   = lane_head[0];
    assign lane0_valid  = !lane_empty[0];
    assign lane1_data   = lane_head[1];
    assign lane1_valid  = !lane_empty[1];
    assign err_overflow = err_overflow_reg;
    assign err_partial  = err_partial_reg;
    assign word_cnt     = word_cnt_reg;

endmodule

// File: tb/tb_demux_lane_sched.sv
// Scoreboard bench: stimulus queues expected lane words, a negedge monitor pops
// and compares them whenever a lane handshake completes.
module tb_demux_lane_sched;

    logic        clk_4f = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        lane0_ready = 1'b0;
    logic        lane1_ready = 1'b0;
    logic        clear_err = 1'b0;
    logic [15:0] lane0_data;
    logic        lane0_valid;
    logic [15:0] lane1_data;
    logic        lane1_valid;
    logic        err_overflow;
    logic        err_partial;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;
    int partial_cnt = 0;
    logic [15:0] exp0 [$];
    logic [15:0] exp1 [$];

    demux_lane_sched #(.FIFO_DEPTH(2), .IDLE_SYM(8'hBC)) dut (
        .clk_4f       (clk_4f),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .lane0_ready  (lane0_ready),
        .lane1_ready  (lane1_ready),
        .clear_err    (clear_err),
        .lane0_data   (lane0_data),
        .lane0_valid  (lane0_valid),
        .lane1_data   (lane1_data),
        .lane1_valid  (lane1_valid),
        .err_overflow (err_overflow),
        .err_partial  (err_partial),
        .word_cnt     (word_cnt)
    );

    always #5 clk_4f = ~clk_4f;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endfunction

    // Monitor: every completed lane handshake must match the scoreboard head.
    always @(negedge clk_4f) begin
        if (reset) begin
            if (lane0_valid && lane0_ready) begin
                if (exp0.size() == 0) check("lane0_unexpected", {16'h0, lane0_data}, 32'hFFFF_FFFF);
                else check("lane0_word", {16'h0, lane0_data}, {16'h0, exp0.pop_front()});
            end
            if (lane1_valid && lane1_ready) begin
                if (exp1.size() == 0) check("lane1_unexpected", {16'h0, lane1_data}, 32'hFFFF_FFFF);
                else check("lane1_word", {16'h0, lane1_data}, {16'h0, exp1.pop_front()});
            end
            if (err_partial) partial_cnt++;
        end
    end

    task automatic send(input logic [7:0] b, input logic v);
        in_data  = b;
        in_valid = v;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_l0v"}, 32'(lane0_valid), 32'h0);
        check({tag, "_l1v"}, 32'(lane1_valid), 32'h0);
        check({tag, "_l0d"}, 32'(lane0_data), 32'h0);
        check({tag, "_l1d"}, 32'(lane1_data), 32'h0);
        check({tag, "_ovf"}, 32'(err_overflow), 32'h0);
        check({tag, "_par"}, 32'(err_partial), 32'h0);
        check({tag, "_cnt"}, 32'(word_cnt), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk_4f);
        #1;
        exp0.delete();
        exp1.delete();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] hb;
        logic [7:0] lb;

        // Reset state
        do_reset();
        check_all_zero("reset");

        // Test 1: idle skipped, two words to alternating lanes
        lane0_ready = 1'b1;
        lane1_ready = 1'b1;
        exp0.push_back(16'h1234);
        exp1.push_back(16'h5678);
        send(8'hBC, 1'b1);
        send(8'h12, 1'b1);
        check("t1_no_bypass", 32'(lane0_valid), 32'h0);
        send(8'h34, 1'b1);
        check("t1_latency_v", 32'(lane0_valid), 32'h1);
        check("t1_latency_d", 32'(lane0_data), 32'h1234);
        send(8'h56, 1'b1);
        send(8'h78, 1'b1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        check("t1_word_cnt", 32'(word_cnt), 32'd2);
        check("t1_ovf", 32'(err_overflow), 32'h0);
        check("t1_partial", 32'(partial_cnt), 32'h0);

        // Test 2: partial word discarded, next pair lands on lane 0
        exp0.push_back(16'hABCD);
        send(8'h12, 1'b1);
        send(8'h00, 1'b0);
        check("t2_partial_hi", 32'(err_partial), 32'h1);
        send(8'hAB, 1'b1);
        check("t2_partial_lo", 32'(err_partial), 32'h0);
        send(8'hCD, 1'b1);
        send(8'h00, 1'b0);
        check("t2_partial_cnt", 32'(partial_cnt), 32'h1);
        check("t2_word_cnt", 32'(word_cnt), 32'd3);

        // Test 3: idle symbol accepted as a low byte
        exp1.push_back(16'h9999);
        send(8'h99, 1'b1);
        send(8'h99, 1'b1);
        exp0.push_back(16'h11BC);
        send(8'h11, 1'b1);
        send(8'hBC, 1'b1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        check("t3_word_cnt", 32'(word_cnt), 32'd5);

        // Test 4: lane 0 stalled, word 4 dropped, lane 1 keeps flowing
        do_reset();
        lane0_ready = 1'b0;
        lane1_ready = 1'b1;
        exp0.push_back(16'h1020);
        exp0.push_back(16'h1222);
        exp1.push_back(16'h1121);
        exp1.push_back(16'h1323);
        exp1.push_back(16'h1525);
        for (int k = 0; k < 6; k++) begin
            hb = 8'h10 + 8'(k);
            lb = 8'h20 + 8'(k);
            send(hb, 1'b1);
            send(lb, 1'b1);
            if (k == 2) check("t4_ovf_before", 32'(err_overflow), 32'h0);
            if (k == 4) check("t4_ovf_after", 32'(err_overflow), 32'h1);
        end
        send(8'h00, 1'b0);
        check("t4_word_cnt", 32'(word_cnt), 32'd6);
        check("t4_l0_head", 32'(lane0_data), 32'h1020);
        check("t4_ovf_sticky", 32'(err_overflow), 32'h1);
        clear_err = 1'b1;
        send(8'h00, 1'b0);
        clear_err = 1'b0;
        check("t4_ovf_clear", 32'(err_overflow), 32'h0);

        // Test 5: full lane 0 popped in the same cycle as a push
        exp0.push_back(16'h1626);
        send(8'h16, 1'b1);
        lane0_ready = 1'b1;
        send(8'h26, 1'b1);
        lane0_ready = 1'b0;
        check("t5_no_ovf", 32'(err_overflow), 32'h0);
        exp1.push_back(16'h1727);
        send(8'h17, 1'b1);
        send(8'h27, 1'b1);
        send(8'h18, 1'b1);
        send(8'h28, 1'b1);
        check("t5_still_full", 32'(err_overflow), 32'h1);
        check("t5_l0_head", 32'(lane0_data), 32'h1222);

        // Test 6: reset mid-word with lane 0 occupied
        send(8'h55, 1'b1);
        reset = 1'b0;
        in_data = 8'h66;
        in_valid = 1'b1;
        @(posedge clk_4f);
        #1;
        exp0.delete();
        exp1.delete();
        reset = 1'b1;
        check_all_zero("t6");
        lane0_ready = 1'b1;
        lane1_ready = 1'b1;
        exp0.push_back(16'h7788);
        send(8'h77, 1'b1);
        check("t6_no_partial", 32'(err_partial), 32'h0);
        send(8'h88, 1'b1);
        repeat (4) send(8'h00, 1'b0);
        check("t6_word_cnt", 32'(word_cnt), 32'd1);
        check("end_exp0_empty", 32'(exp0.size()), 32'h0);
        check("end_exp1_empty", 32'(exp1.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
